// File: rtl/svm_cfu_pkg.sv
// Shared definitions for the linear-SVM argmax CFU: opcode encodings,
// lane-mode and FSM state enums, and the signed saturation helper.
package svm_cfu_pkg;

  localparam logic [2:0] OP_MAC4       = 3'b000;
  localparam logic [2:0] OP_MAC8       = 3'b001;
  localparam logic [2:0] OP_MAC16      = 3'b010;
  localparam logic [2:0] OP_CLOSE      = 3'b011;
  localparam logic [2:0] OP_GET_MAX    = 3'b100;
  localparam logic [2:0] OP_READ_SCORE = 3'b101;
  localparam logic [2:0] OP_RSVD       = 3'b110;
  localparam logic [2:0] OP_CLEAR      = 3'b111;

  typedef enum logic [1:0] {
    LANE_4B,
    LANE_8B,
    LANE_16B
  } lane_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  // Clamp a wide signed value into the range of a 'width'-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/svm_lane_dot.sv
// Packed dot product of unsigned features against signed weights.
// Lane width follows mode_i: 8x4b, 4x8b or 2x16b; the lane sum is
// carried at ACC_W+4 bits so the accumulator sees the full-precision result.
module svm_lane_dot
  import svm_cfu_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  lane_mode_e               mode_i,
  input  logic [31:0]              rs1_i,
  input  logic [31:0]              rs2_i,
  output logic signed [ACC_W+3:0]  lanesum_o
);

  localparam int SW = ACC_W + 4;

  logic signed [SW-1:0] acc;

  // Sum the per-lane products; features get a zero sign bit, weights stay signed.
  always_comb begin
    acc = '0;
    case (mode_i)
      LANE_8B: begin
        for (int i = 0; i < 4; i++) begin
          acc = acc + SW'($signed({1'b0, rs1_i[8*i +: 8]})) * SW'($signed(rs2_i[8*i +: 8]));
        end
      end
      LANE_16B: begin
        for (int i = 0; i < 2; i++) begin
          acc = acc + SW'($signed({1'b0, rs1_i[16*i +: 16]})) * SW'($signed(rs2_i[16*i +: 16]));
        end
      end
      default: begin
        for (int i = 0; i < 8; i++) begin
          acc = acc + SW'($signed({1'b0, rs1_i[4*i +: 4]})) * SW'($signed(rs2_i[4*i +: 4]));
        end
      end
    endcase
    lanesum_o = acc;
  end

endmodule

// File: rtl/svm_argmax_cfu.sv
// Multi-class linear-SVM scoring CFU: accumulates packed dot products,
// closes each class with a bias, and tracks the running argmax.
// Define SVM_SCORE_BUF_EN to keep a per-class score buffer readable by
// READ_SCORE; without it READ_SCORE returns zero and CLOSE stores nothing.
module svm_argmax_cfu
  import svm_cfu_pkg::*;
#(
  parameter int ACC_W       = 32,
  parameter int ID_W        = 8,
  parameter int MAX_CLASSES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfu_valid,
  input  logic [2:0]  i_cfu_op,
  input  logic [31:0] i_cfu_rs1,
  input  logic [31:0] i_cfu_rs2,
  output logic        o_cfu_ready,
  output logic [31:0] o_cfu_rd
);

  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ID_W-1:0]         ID_LIMIT = ID_W'(MAX_CLASSES);

  state_e                   state_q;
  logic [2:0]               op_q;
  logic [31:0]              rs1_q;
  logic [31:0]              rs2_q;
  logic                     ready_q;
  logic [31:0]              rd_q;
  logic [31:0]              rd_d;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  curMax_q;
  logic signed [ACC_W-1:0]  curMax_d;
  logic [ID_W-1:0]          id_q;
  logic [ID_W-1:0]          id_d;
  logic [ID_W-1:0]          maxId_q;
  logic [ID_W-1:0]          maxId_d;
  logic                     ovf_q;
  logic                     ovf_d;
  logic                     clearAll;
  lane_mode_e               laneMode;
  logic signed [ACC_W+3:0]  laneSum;
  logic signed [ACC_W-1:0]  macSum;
  logic signed [ACC_W-1:0]  score;

`ifdef SVM_SCORE_BUF_EN
  logic signed [ACC_W-1:0]  buf_q [MAX_CLASSES];
  logic                     wrEn;
  logic signed [ACC_W-1:0]  readVal;

  // Score lookup; indices beyond the buffer fall through to zero.
  always_comb begin
    readVal = '0;
    for (int k = 0; k < MAX_CLASSES; k++) begin
      if (rs1_q[ID_W-1:0] == ID_W'(k)) begin
        readVal = buf_q[k];
      end
    end
  end
`endif

  // Lane width is implied by which MAC opcode was latched.
  always_comb begin
    case (op_q)
      OP_MAC8:  laneMode = LANE_8B;
      OP_MAC16: laneMode = LANE_16B;
      default:  laneMode = LANE_4B;
    endcase
  end

  svm_lane_dot #(
    .ACC_W(ACC_W)
  ) uLaneDot (
    .mode_i   (laneMode),
    .rs1_i    (rs1_q),
    .rs2_i    (rs2_q),
    .lanesum_o(laneSum)
  );

  assign macSum = ACC_W'(saturate(64'(sum_q) + 64'(laneSum), ACC_W));
  assign score  = ACC_W'(saturate(64'(sum_q) + 64'($signed(rs1_q[ACC_W-1:0])), ACC_W));

  // Next data state and response word for the latched command.
  always_comb begin
    sum_d    = sum_q;
    curMax_d = curMax_q;
    id_d     = id_q;
    maxId_d  = maxId_q;
    ovf_d    = ovf_q;
    rd_d     = '0;
    clearAll = 1'b0;
`ifdef SVM_SCORE_BUF_EN
    wrEn     = 1'b0;
`endif
    case (op_q)
      OP_MAC4, OP_MAC8, OP_MAC16: begin
        sum_d = macSum;
      end
      OP_CLOSE: begin
        sum_d = '0;
        if (id_q == ID_LIMIT) begin
          ovf_d = 1'b1;
        end else begin
          if (score > curMax_q) begin
            curMax_d = score;
            maxId_d  = id_q;
          end
          id_d = id_q + ID_W'(1);
`ifdef SVM_SCORE_BUF_EN
          wrEn = 1'b1;
`endif
        end
        rd_d[31]         = score[ACC_W-1];
        rd_d[30]         = ovf_d;
        rd_d[ID_W-1:0]   = maxId_d;
      end
      OP_GET_MAX: begin
        rd_d = 32'(curMax_q);
      end
      OP_READ_SCORE: begin
`ifdef SVM_SCORE_BUF_EN
        rd_d = 32'(readVal);
`endif
      end
      OP_CLEAR: begin
        clearAll = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Command FSM: latch in IDLE, commit in EXEC, strobe the response in RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      rd_q     <= '0;
      op_q     <= OP_MAC4;
      rs1_q    <= '0;
      rs2_q    <= '0;
      sum_q    <= '0;
      curMax_q <= ACC_MIN;
      id_q     <= '0;
      maxId_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef SVM_SCORE_BUF_EN
      for (int k = 0; k < MAX_CLASSES; k++) begin
        buf_q[k] <= '0;
      end
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          rd_q    <= '0;
          if (i_cfu_valid) begin
            op_q    <= i_cfu_op;
            rs1_q   <= i_cfu_rs1;
            rs2_q   <= i_cfu_rs2;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q <= ST_RESP;
          ready_q <= 1'b1;
          rd_q    <= rd_d;
          if (clearAll) begin
            sum_q    <= '0;
            curMax_q <= ACC_MIN;
            id_q     <= '0;
            maxId_q  <= '0;
            ovf_q    <= 1'b0;
`ifdef SVM_SCORE_BUF_EN
            for (int k = 0; k < MAX_CLASSES; k++) begin
              buf_q[k] <= '0;
            end
`endif
          end else begin
            sum_q    <= sum_d;
            curMax_q <= curMax_d;
            id_q     <= id_d;
            maxId_q  <= maxId_d;
            ovf_q    <= ovf_d;
`ifdef SVM_SCORE_BUF_EN
            if (wrEn) begin
              for (int k = 0; k < MAX_CLASSES; k++) begin
                if (id_q == ID_W'(k)) begin
                  buf_q[k] <= score;
                end
              end
            end
`endif
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          rd_q    <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cfu_ready = ready_q;
  assign o_cfu_rd    = rd_q;

endmodule

// File: tb/tb_svm_argmax_cfu.sv
// Directed bench for svm_argmax_cfu built with MAX_CLASSES=4 so the class
// limit is reachable; expected buffer reads follow SVM_SCORE_BUF_EN.
module tb_svm_argmax_cfu;
  import svm_cfu_pkg::*;

  localparam int ACC_W       = 32;
  localparam int ID_W        = 8;
  localparam int MAX_CLASSES = 4;

`ifdef SVM_SCORE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] expRd;
    string       name;
  } vec_t;

  vec_t vecs[$];

  svm_argmax_cfu #(
    .ACC_W      (ACC_W),
    .ID_W       (ID_W),
    .MAX_CLASSES(MAX_CLASSES)
  ) dut (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_cfu_valid(valid),
    .i_cfu_op   (op),
    .i_cfu_rs1  (rs1),
    .i_cfu_rs2  (rs2),
    .o_cfu_ready(ready),
    .o_cfu_rd   (rd)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one command and hold valid until the ready strobe arrives.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] result);
    bit seen;
    seen   = 1'b0;
    result = 'x;
    @(negedge clock);
    valid = 1'b1;
    op    = opIn;
    rs1   = a;
    rs2   = b;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        seen   = 1'b1;
        result = rd;
        valid  = 1'b0;
      end
    end
    if (!seen) begin
      valid = 1'b0;
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: op %0d got no ready in 8 cycles, expected ready", opIn);
    end
  endtask

  function automatic void addVec(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] e,
                                 input string n);
    vec_t v;
    v.op    = o;
    v.rs1   = a;
    v.rs2   = b;
    v.expRd = e;
    v.name  = n;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] r;
    int readyCount;
    bit seenFlag;

    reset = 1'b1;
    valid = 1'b0;
    op    = 3'b000;
    rs1   = '0;
    rs2   = '0;

    // Case 1: MAC4 of 8 lanes 1 x -1 = -8.
    addVec(OP_CLEAR,      32'h0,        32'h0,        32'h0,        "t1 clear");
    addVec(OP_MAC4,       32'h11111111, 32'hFFFFFFFF, 32'h0,        "t1 mac4");
    addVec(OP_CLOSE,      32'h0,        32'h0,        32'h80000000, "t1 close");
    addVec(OP_GET_MAX,    32'h0,        32'h0,        32'hFFFFFFF8, "t1 get_max");
    // Case 2: MAC8 4 x 2*127 = 1016, bias 8 -> 1024.
    addVec(OP_CLEAR,      32'h0,        32'h0,        32'h0,        "t2 clear");
    addVec(OP_MAC8,       32'h02020202, 32'h7F7F7F7F, 32'h0,        "t2 mac8");
    addVec(OP_CLOSE,      32'h8,        32'h0,        32'h0,        "t2 close");
    addVec(OP_GET_MAX,    32'h0,        32'h0,        32'h00000400, "t2 get_max");
    addVec(OP_READ_SCORE, 32'h0,        32'h0,        BUF_EN ? 32'h400 : 32'h0, "t2 read_score0");
    // Case 3: ties keep the lower id, strictly larger score wins.
    addVec(OP_CLEAR,      32'h0,        32'h0,        32'h0,        "t3 clear");
    addVec(OP_CLOSE,      32'h5,        32'h0,        32'h0,        "t3 close0");
    addVec(OP_CLOSE,      32'h5,        32'h0,        32'h0,        "t3 close1 tie");
    addVec(OP_CLOSE,      32'h6,        32'h0,        32'h2,        "t3 close2");
    addVec(OP_GET_MAX,    32'h0,        32'h0,        32'h6,        "t3 get_max");
    addVec(OP_READ_SCORE, 32'h1,        32'h0,        BUF_EN ? 32'h5 : 32'h0, "t3 read_score1");
    // Case 4: MAC16 positive saturation.
    addVec(OP_CLEAR,      32'h0,        32'h0,        32'h0,        "t4 clear");
    addVec(OP_MAC16,      32'hFFFFFFFF, 32'h7FFF7FFF, 32'h0,        "t4 mac16");
    addVec(OP_CLOSE,      32'h1,        32'h0,        32'h0,        "t4 close");
    addVec(OP_GET_MAX,    32'h0,        32'h0,        32'h7FFFFFFF, "t4 get_max");
    addVec(OP_RSVD,       32'h7B,       32'h55,       32'h0,        "reserved op");
    addVec(OP_GET_MAX,    32'h0,        32'h0,        32'h7FFFFFFF, "get_max after reserved");
    // Negative saturation; a score equal to the minimum does not beat it.
    addVec(OP_CLEAR,      32'h0,        32'h0,        32'h0,        "neg clear");
    addVec(OP_MAC16,      32'hFFFFFFFF, 32'h80008000, 32'h0,        "neg mac16");
    addVec(OP_CLOSE,      32'hFFFFFFFF, 32'h0,        32'h80000000, "neg close");
    addVec(OP_GET_MAX,    32'h0,        32'h0,        32'h80000000, "neg get_max");
    // Accumulation across modes: 15*7 + 255*(-128) = -32535.
    addVec(OP_CLEAR,      32'h0,        32'h0,        32'h0,        "acc clear");
    addVec(OP_MAC4,       32'h0000000F, 32'h00000007, 32'h0,        "acc mac4");
    addVec(OP_MAC8,       32'h000000FF, 32'h00000080, 32'h0,        "acc mac8");
    addVec(OP_CLOSE,      32'h0,        32'h0,        32'h80000000, "acc close");
    addVec(OP_GET_MAX,    32'h0,        32'h0,        32'hFFFF80E9, "acc get_max");

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset ready", {31'b0, ready}, 32'h0);
    checkOutput("reset rd", rd, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(OP_GET_MAX, 32'h0, 32'h0, r);
    checkOutput("reset cur_max", r, 32'h80000000);
    applyStimulus(OP_READ_SCORE, 32'h0, 32'h0, r);
    checkOutput("reset read_score", r, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, r);
      checkOutput(vecs[i].name, r, vecs[i].expRd);
    end

    // Class limit: four CLOSEs fill the classes, later ones set ovf.
    applyStimulus(OP_CLEAR, 32'h0, 32'h0, r);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_CLOSE, 32'(i + 1), 32'h0, r);
      checkOutput($sformatf("limit close%0d", i), r, 32'(i));
    end
    applyStimulus(OP_MAC8, 32'h1, 32'hFF, r);
    applyStimulus(OP_CLOSE, 32'h0, 32'h0, r);
    checkOutput("limit close4 ovf", r, 32'hC0000003);
    applyStimulus(OP_CLOSE, 32'h0, 32'h0, r);
    checkOutput("limit close5 sum cleared", r, 32'h40000003);
    applyStimulus(OP_READ_SCORE, 32'h4, 32'h0, r);
    checkOutput("limit read_score4", r, 32'h0);
    applyStimulus(OP_READ_SCORE, 32'h3, 32'h0, r);
    checkOutput("limit read_score3", r, BUF_EN ? 32'h4 : 32'h0);
    applyStimulus(OP_GET_MAX, 32'h0, 32'h0, r);
    checkOutput("limit get_max", r, 32'h4);
    applyStimulus(OP_CLEAR, 32'h0, 32'h0, r);
    applyStimulus(OP_CLOSE, 32'h1, 32'h0, r);
    checkOutput("ovf cleared", r, 32'h0);

    // Dropping valid during EXEC still completes the command.
    @(posedge clock);
    @(negedge clock);
    valid = 1'b1;
    op    = OP_GET_MAX;
    @(posedge clock);
    #1;
    valid = 1'b0;
    seenFlag = 1'b0;
    r = 'x;
    for (int c = 0; c < 4 && !seenFlag; c++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        seenFlag = 1'b1;
        r = rd;
      end
    end
    checkOutput("dropped valid ready", {31'b0, seenFlag}, 32'h1);
    checkOutput("dropped valid rd", r, 32'h1);

    // Valid held through RESP must not start a second command.
    applyStimulus(OP_CLEAR, 32'h0, 32'h0, r);
    @(posedge clock);
    @(negedge clock);
    valid = 1'b1;
    op    = OP_MAC8;
    rs1   = 32'h1;
    rs2   = 32'h1;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("held valid first ready", {31'b0, ready}, 32'h1);
    @(posedge clock);
    #1;
    valid = 1'b0;
    readyCount = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      if (ready) readyCount++;
    end
    checkOutput("held valid extra ready", 32'(readyCount), 32'h0);
    applyStimulus(OP_CLOSE, 32'h0, 32'h0, r);
    checkOutput("held valid close", r, 32'h0);
    applyStimulus(OP_GET_MAX, 32'h0, 32'h0, r);
    checkOutput("held valid single mac", r, 32'h1);

    // Reset during EXEC aborts without a response.
    @(posedge clock);
    @(negedge clock);
    valid = 1'b1;
    op    = OP_MAC8;
    rs1   = 32'h1;
    rs2   = 32'h1;
    @(posedge clock);
    #1;
    valid = 1'b0;
    reset = 1'b1;
    readyCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      if (ready) readyCount++;
    end
    checkOutput("reset in exec ready", 32'(readyCount), 32'h0);
    checkOutput("reset in exec rd", rd, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(OP_GET_MAX, 32'h0, 32'h0, r);
    checkOutput("after reset get_max", r, 32'h80000000);
    applyStimulus(OP_READ_SCORE, 32'h0, 32'h0, r);
    checkOutput("after reset read_score0", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
